// File: rtl/logic_pod_pkg.sv
// Shared definitions for the logic pod RAM writer: descriptor layout, burst shape,
// staging entry type and FSM encodings.
package logic_pod_pkg;

  localparam int unsigned ADDR_DESC_WIDTH  = 29;
  localparam int unsigned ADDR_DESC_WR_BIT = 28;
  localparam int unsigned POD_BIT          = 27;
  localparam int unsigned CHAN_MSB         = 26;
  localparam int unsigned CHAN_LSB         = 24;
  localparam int unsigned PTR_MSB          = 23;
  localparam int unsigned PTR_LSB          = 2;
  localparam int unsigned BURST_ADDR_WIDTH = 28;
  localparam int unsigned BURST_BEATS      = 2;
  localparam int unsigned DATA_WIDTH       = 256;

  localparam logic [2:0] APP_CMD_WRITE = 3'b000;

  typedef struct packed {
    logic [BURST_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]       beat0;
    logic [DATA_WIDTH-1:0]       beat1;
  } burst_entry_t;

  typedef enum logic [1:0] {FtIdle, FtBeat0, FtBeat1} fetch_state_e;
  typedef enum logic [1:0] {IsBeat0, IsBeat1, IsDataDone} issue_state_e;

  function automatic logic desc_is_valid(input logic [ADDR_DESC_WIDTH-1:0] desc,
                                         input logic pod_lsb);
    return desc[ADDR_DESC_WR_BIT] && (desc[POD_BIT] == pod_lsb);
  endfunction

  // Rebuilds the burst address from its named fields; the low bits are always zero
  // in a well-formed descriptor but are carried through unchanged.
  function automatic logic [BURST_ADDR_WIDTH-1:0] desc_addr(
      input logic [ADDR_DESC_WIDTH-1:0] desc);
    return {desc[POD_BIT], desc[CHAN_MSB:CHAN_LSB], desc[PTR_MSB:PTR_LSB],
            desc[PTR_LSB-1:0]};
  endfunction

endpackage

// File: rtl/logic_pod_ram_writer_burst_stage.sv
// Two-entry staging queue of complete bursts; occupancy also counts reserved
// (in-flight) slots so the fetch unit never overcommits.
module logic_pod_burst_stage
  import logic_pod_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_reserve,
  input  logic         i_push,
  input  logic         i_cancel,
  input  logic         i_pop,
  input  burst_entry_t i_push_entry,
  output logic         o_head_valid,
  output burst_entry_t o_head,
  output logic [1:0]   o_occupancy
);

  burst_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_held;
  logic [1:0]   r_occ;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_held   <= 2'd0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_held <= r_held + {1'b0, i_push} - {1'b0, i_pop};
      // A push turns a reserved slot into a held one, so it leaves occupancy alone.
      r_occ  <= r_occ + {1'b0, i_reserve} - {1'b0, i_pop} - {1'b0, i_cancel};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  assign o_head_valid = (r_held != 2'd0);
  assign o_head       = r_mem[r_rd_ptr];
  assign o_occupancy  = r_occ;

endmodule

// File: rtl/logic_pod_ram_writer.sv
// Drains descriptor and data FIFOs into 512-bit DRAM write bursts (one command plus
// two 256-bit beats), with a two-entry staging queue between fetch and issue.
module logic_pod_ram_writer
  import logic_pod_pkg::*;
#(
  parameter int unsigned POD_NUMBER     = 0,
  parameter int unsigned APP_ADDR_WIDTH = 29
) (
  input  logic                       clk_ram,
  input  logic                       rst,
  output logic                       addr_fifo_rd_en,
  input  logic [ADDR_DESC_WIDTH-1:0] addr_fifo_rd_data,
  input  logic [7:0]                 addr_fifo_rd_size,
  output logic                       data_fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]      data_fifo_rd_data,
  input  logic [8:0]                 data_fifo_rd_size,
  output logic                       app_en,
  output logic [2:0]                 app_cmd,
  output logic [APP_ADDR_WIDTH-1:0]  app_addr,
  input  logic                       app_rdy,
  output logic                       app_wdf_wren,
  output logic [DATA_WIDTH-1:0]      app_wdf_data,
  output logic                       app_wdf_end,
  input  logic                       app_wdf_rdy,
  output logic                       idle,
  output logic [31:0]                burst_count,
  output logic [15:0]                bad_desc_count
);

  localparam logic POD_LSB = 1'(POD_NUMBER % 2);

  fetch_state_e                r_fetch_state, w_fetch_state_d;
  issue_state_e                r_iss_state, w_iss_state_d;
  logic                        r_addr_pop, r_data_pop;
  logic                        r_desc_ok;
  logic [BURST_ADDR_WIDTH-1:0] r_desc_addr;
  logic [DATA_WIDTH-1:0]       r_beat0;
  logic                        r_cmd_done;
  logic [31:0]                 r_burst_count;
  logic [15:0]                 r_bad_count;
  logic                        r_idle;

  logic         w_launch, w_capture, w_complete, w_push, w_cancel;
  logic         w_addr_ok, w_data_ok, w_space;
  logic [1:0]   w_occupancy, w_occ_eff;
  logic         w_head_valid;
  burst_entry_t w_head, w_push_entry;
  logic         w_cmd_fire, w_beat_fire, w_data_done, w_cmd_done, w_retire;

  // Size inputs lag one cycle behind a pop, so last cycle's pops are discounted.
  assign w_addr_ok = addr_fifo_rd_size > {7'd0, r_addr_pop};
  assign w_data_ok = data_fifo_rd_size >= (9'd2 + {8'd0, r_data_pop});
  assign w_occ_eff = w_occupancy - {1'b0, w_retire} - {1'b0, w_cancel};
  assign w_space   = w_occ_eff < 2'd2;
  assign w_launch  = ((r_fetch_state == FtIdle) || (r_fetch_state == FtBeat1)) &&
                     w_space && w_addr_ok && w_data_ok;

  always_ff @(posedge clk_ram or posedge rst) begin
    if (rst) r_fetch_state <= FtIdle;
    else     r_fetch_state <= w_fetch_state_d;
  end

  always_comb begin
    w_fetch_state_d = r_fetch_state;
    unique case (r_fetch_state)
      FtIdle:  if (w_launch) w_fetch_state_d = FtBeat0;
      FtBeat0: w_fetch_state_d = FtBeat1;
      FtBeat1: w_fetch_state_d = w_launch ? FtBeat0 : FtIdle;
      default: w_fetch_state_d = FtIdle;
    endcase
  end

  always_comb begin
    addr_fifo_rd_en = w_launch;
    data_fifo_rd_en = w_launch || (r_fetch_state == FtBeat0);
    w_capture       = (r_fetch_state == FtBeat0);
    w_complete      = (r_fetch_state == FtBeat1);
  end

  always_ff @(posedge clk_ram or posedge rst) begin
    if (rst) begin
      r_addr_pop  <= 1'b0;
      r_data_pop  <= 1'b0;
      r_desc_ok   <= 1'b0;
      r_desc_addr <= '0;
      r_beat0     <= '0;
    end else begin
      r_addr_pop <= addr_fifo_rd_en;
      r_data_pop <= data_fifo_rd_en;
      if (w_capture) begin
        r_desc_ok   <= desc_is_valid(addr_fifo_rd_data, POD_LSB);
        r_desc_addr <= desc_addr(addr_fifo_rd_data);
        r_beat0     <= data_fifo_rd_data;
      end
    end
  end

  // Bad descriptors still consume both data words; they simply release their slot.
  assign w_push       = w_complete && r_desc_ok;
  assign w_cancel     = w_complete && !r_desc_ok;
  assign w_push_entry = '{addr: r_desc_addr, beat0: r_beat0, beat1: data_fifo_rd_data};

  logic_pod_burst_stage u_stage (
    .i_clk        (clk_ram),
    .i_rst        (rst),
    .i_reserve    (w_launch),
    .i_push       (w_push),
    .i_cancel     (w_cancel),
    .i_pop        (w_retire),
    .i_push_entry (w_push_entry),
    .o_head_valid (w_head_valid),
    .o_head       (w_head),
    .o_occupancy  (w_occupancy)
  );

  assign w_cmd_fire  = app_en && app_rdy;
  assign w_beat_fire = app_wdf_wren && app_wdf_rdy;
  assign w_data_done = (r_iss_state == IsDataDone) ||
                       ((r_iss_state == IsBeat1) && w_beat_fire);
  assign w_cmd_done  = r_cmd_done || w_cmd_fire;
  assign w_retire    = w_head_valid && w_data_done && w_cmd_done;

  always_ff @(posedge clk_ram or posedge rst) begin
    if (rst) begin
      r_iss_state <= IsBeat0;
      r_cmd_done  <= 1'b0;
    end else begin
      r_iss_state <= w_iss_state_d;
      r_cmd_done  <= w_retire ? 1'b0 : w_cmd_done;
    end
  end

  always_comb begin
    w_iss_state_d = r_iss_state;
    if (w_retire) begin
      w_iss_state_d = IsBeat0;
    end else begin
      unique case (r_iss_state)
        IsBeat0:    if (w_beat_fire) w_iss_state_d = IsBeat1;
        IsBeat1:    if (w_beat_fire) w_iss_state_d = IsDataDone;
        IsDataDone: w_iss_state_d = IsDataDone;
        default:    w_iss_state_d = IsBeat0;
      endcase
    end
  end

  always_comb begin
    app_en       = w_head_valid && !r_cmd_done;
    app_cmd      = APP_CMD_WRITE;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    app_wdf_data = '0;
    if (app_en) app_addr = APP_ADDR_WIDTH'(w_head.addr);
    if (w_head_valid) begin
      unique case (r_iss_state)
        IsBeat0: begin
          app_wdf_wren = 1'b1;
          app_wdf_data = w_head.beat0;
        end
        IsBeat1: begin
          app_wdf_wren = 1'b1;
          app_wdf_end  = 1'b1;
          app_wdf_data = w_head.beat1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_ram or posedge rst) begin
    if (rst) begin
      r_burst_count <= 32'd0;
      r_bad_count   <= 16'd0;
      r_idle        <= 1'b1;
    end else begin
      if (w_retire) r_burst_count <= r_burst_count + 32'd1;
      if (w_cancel && (r_bad_count != 16'hFFFF)) r_bad_count <= r_bad_count + 16'd1;
      r_idle <= (w_occupancy == 2'd0) && !app_en && !app_wdf_wren;
    end
  end

  assign idle           = r_idle;
  assign burst_count    = r_burst_count;
  assign bad_desc_count = r_bad_count;

endmodule
